// File: rtl/color_pkg.sv
// Shared colour/filter codes, ASCII message bytes and state encodings for the
// colour detector and its UART event reporter.
package color_pkg;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    localparam logic [1:0] FILT_RED    = 2'd0;
    localparam logic [1:0] FILT_BLUE   = 2'd1;
    localparam logic [1:0] FILT_CLEAR  = 2'd2;
    localparam logic [1:0] FILT_GREEN  = 2'd3;

    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_G  = 8'h47;
    localparam logic [7:0] ASC_B  = 8'h42;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic       {SEQ_IDLE, SEQ_SEND} seq_state_e;

    // Byte idx (0..2) of the report message for colour col.
    function automatic logic [7:0] msg_byte(input logic [1:0] col, input logic [1:0] idx);
        logic [7:0] b;
        b = ASC_LF;
        if (idx == 2'd0) begin
            case (col)
                COLOR_RED:   b = ASC_R;
                COLOR_GREEN: b = ASC_G;
                COLOR_BLUE:  b = ASC_B;
                default:     b = 8'h00;
            endcase
        end else if (idx == 2'd1) begin
            b = ASC_CR;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 transmitter for a single byte. A start accepted in the last stop-bit
// cycle chains straight into the next start bit with no idle gap.
module uart_tx_byte
    import color_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
        end
    end

    assign last = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == TX_IDLE) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    sh_d    = data;
                end
            end
            TX_START: begin
                if (last) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (last) begin
                    done  = 1'b1;
                    cnt_d = '0;
                    if (start) begin
                        state_d = TX_START;
                        sh_d    = data;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx = (state_q == TX_START) ? 1'b0 :
                (state_q == TX_DATA)  ? sh_q[0] : 1'b1;

endmodule

// File: rtl/color_event_uart.sv
// Confirms detector colours over consecutive rounds and reports each newly
// confirmed non-zero colour as "<R|G|B>\r\n" on an 8N1 UART line.
module color_event_uart
    import color_pkg::*;
#(
    parameter int CONFIRM_CNT  = 3,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic [1:0] filter,
    input  logic [1:0] color,
    output logic       tx,
    output logic       busy,
    output logic [1:0] stable_color,
    output logic       event_pulse
);

    localparam logic [3:0] LIM = 4'(CONFIRM_CNT);

    logic [1:0] filter_q;
    logic [1:0] cand_q, cand_d;
    logic [3:0] run_q, run_d;
    logic [1:0] stable_q, stable_d;
    logic       pulse_q, pulse_d;
    seq_state_e seq_q, seq_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] col_q, col_d;
    logic       pend_vld_q, pend_vld_d;
    logic [1:0] pend_col_q, pend_col_d;
    logic       sample, hit, byte_start, byte_done;
    logic [7:0] byte_data;

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            filter_q   <= FILT_RED;
            cand_q     <= COLOR_NONE;
            run_q      <= '0;
            stable_q   <= COLOR_NONE;
            pulse_q    <= 1'b0;
            seq_q      <= SEQ_IDLE;
            idx_q      <= '0;
            col_q      <= COLOR_NONE;
            pend_vld_q <= 1'b0;
            pend_col_q <= COLOR_NONE;
        end else begin
            filter_q   <= filter;
            cand_q     <= cand_d;
            run_q      <= run_d;
            stable_q   <= stable_d;
            pulse_q    <= pulse_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            pend_vld_q <= pend_vld_d;
            pend_col_q <= pend_col_d;
        end
    end

    // The detector publishes a fresh colour as it steps from blue to clear.
    assign sample = (filter == FILT_CLEAR) && (filter_q == FILT_BLUE);

    always_comb begin
        cand_d   = cand_q;
        run_d    = run_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        hit      = 1'b0;
        if (sample) begin
            if (color == cand_q) begin
                if (run_q != LIM) begin
                    run_d = run_q + 4'd1;
                    hit   = (run_d == LIM);
                end
            end else begin
                cand_d = color;
                run_d  = 4'd1;
                hit    = (LIM == 4'd1);
            end
        end
        if (hit && (cand_d != stable_q)) begin
            stable_d = cand_d;
            pulse_d  = (cand_d != COLOR_NONE);
        end
    end

    // The pulse cycle doubles as the message request; stable_q holds its colour.
    always_comb begin
        seq_d      = seq_q;
        idx_d      = idx_q;
        col_d      = col_q;
        pend_vld_d = pend_vld_q;
        pend_col_d = pend_col_q;
        byte_start = 1'b0;
        case (seq_q)
            SEQ_IDLE: begin
                if (pulse_q) begin
                    seq_d      = SEQ_SEND;
                    idx_d      = 2'd0;
                    col_d      = stable_q;
                    byte_start = 1'b1;
                end
            end
            SEQ_SEND: begin
                if (byte_done && idx_q != 2'd2) begin
                    idx_d      = idx_q + 2'd1;
                    byte_start = 1'b1;
                end else if (byte_done) begin
                    if (pulse_q || pend_vld_q) begin
                        idx_d      = 2'd0;
                        col_d      = pulse_q ? stable_q : pend_col_q;
                        pend_vld_d = 1'b0;
                        byte_start = 1'b1;
                    end else begin
                        seq_d = SEQ_IDLE;
                    end
                end
                if (pulse_q && !(byte_done && idx_q == 2'd2)) begin
                    pend_vld_d = 1'b1;
                    pend_col_d = stable_q;
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    assign byte_data = msg_byte(col_d, idx_d);

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk_1MHz),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .done  (byte_done)
    );

    assign busy         = (seq_q == SEQ_SEND);
    assign stable_color = stable_q;
    assign event_pulse  = pulse_q;

endmodule

// File: tb/tb_color_event_uart.sv
// Directed bench for color_event_uart: confirmation rules, message framing,
// pending overwrite with back-to-back messages, and asynchronous reset.
module tb_color_event_uart;
    import color_pkg::*;

    localparam int CPB   = 104;
    localparam int FRAME = 10 * CPB;

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic [1:0] filter   = 2'd0;
    logic [1:0] color    = 2'd0;
    logic       tx, busy, event_pulse;
    logic [1:0] stable_color;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic       txs [0:6*FRAME-1];
    logic [7:0] rx  [0:5];
    logic [7:0] exp_b [0:5];
    int         busy_low, wave_err, end_busy;
    bit         started;

    color_event_uart #(.CONFIRM_CNT(3), .CLKS_PER_BIT(CPB)) dut (
        .clk_1MHz     (clk_1MHz),
        .rst          (rst),
        .filter       (filter),
        .color        (color),
        .tx           (tx),
        .busy         (busy),
        .stable_color (stable_color),
        .event_pulse  (event_pulse)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    always @(negedge clk_1MHz) if (event_pulse) pulse_cnt++;

    // One detector round: blue then clear, colour presented with the clear step.
    task automatic do_sample(input logic [1:0] c);
        @(posedge clk_1MHz); #1 filter = FILT_BLUE;
        @(posedge clk_1MHz); #1 filter = FILT_CLEAR; color = c;
        @(posedge clk_1MHz); #1 filter = FILT_RED;
    endtask

    // Wait for busy, record tx for nbytes frames, decode, compare to the
    // ideal waveform built from exp_b, then sample busy one cycle later.
    task automatic capture(input int nbytes);
        int n;
        int b, k, pos;
        logic [9:0] fr;
        logic lvl;
        started = 0; n = 0;
        while (!started && n < 40) begin
            @(negedge clk_1MHz);
            if (busy) started = 1;
            n++;
        end
        busy_low = 0; wave_err = 0;
        if (started) begin
            for (int i = 0; i < nbytes * FRAME; i++) begin
                if (i > 0) @(negedge clk_1MHz);
                txs[i] = tx;
                if (!busy) busy_low++;
            end
            for (int i = 0; i < nbytes * FRAME; i++) begin
                b   = i / FRAME;
                pos = (i % FRAME) / CPB;
                fr  = {1'b1, exp_b[b], 1'b0};
                lvl = fr[pos];
                if (txs[i] !== lvl) wave_err++;
            end
            for (int j = 0; j < nbytes; j++)
                for (k = 0; k < 8; k++) rx[j][k] = txs[j*FRAME + (k+1)*CPB + CPB/2];
            @(negedge clk_1MHz);
            end_busy = busy;
        end
    endtask

    task automatic check_msg(input string name, input int nbytes, input int exp_end_busy);
        checks++;
        if (!started) begin
            errors++; $display("FAIL %s start: busy never rose", name);
        end
        for (int j = 0; j < nbytes; j++) begin
            checks++;
            if (rx[j] !== exp_b[j]) begin
                errors++; $display("FAIL %s byte%0d: got %h want %h", name, j, rx[j], exp_b[j]);
            end
        end
        checks++;
        if (wave_err !== 0) begin
            errors++; $display("FAIL %s waveform: %0d bad cycles want 0", name, wave_err);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++; $display("FAIL %s busy gap: %0d low cycles want 0", name, busy_low);
        end
        checks++;
        if (end_busy !== exp_end_busy) begin
            errors++; $display("FAIL %s busy end: got %0d want %0d", name, end_busy, exp_end_busy);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tx, busy, stable_color, event_pulse} !== 5'b1_0_00_0) begin
            errors++; $display("FAIL reset: tx/busy/stable/pulse %b want 10000",
                               {tx, busy, stable_color, event_pulse});
        end
        repeat (3) @(posedge clk_1MHz);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk_1MHz);
        checks++;
        if ({tx, busy, stable_color, event_pulse} !== 5'b1_0_00_0) begin
            errors++; $display("FAIL reset idle: got %b want 10000",
                               {tx, busy, stable_color, event_pulse});
        end
    endtask

    task automatic test_confirm_red();
        int p0;
        p0 = pulse_cnt;
        do_sample(COLOR_RED);
        do_sample(COLOR_RED);
        checks++;
        if (stable_color !== 2'd0 || pulse_cnt !== p0) begin
            errors++; $display("FAIL red early: stable %0d pulses %0d want 0 0", stable_color, pulse_cnt - p0);
        end
        do_sample(COLOR_RED);
        checks++;
        if (event_pulse !== 1'b1 || stable_color !== COLOR_RED || busy !== 1'b0) begin
            errors++; $display("FAIL red confirm: pulse %b stable %0d busy %b want 1 1 0",
                               event_pulse, stable_color, busy);
        end
        exp_b[0] = 8'h52; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        capture(3);
        check_msg("red", 3, 0);
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++; $display("FAIL red pulses: got %0d want 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_steady();
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 7; i++) do_sample(COLOR_RED);
        repeat (10) @(negedge clk_1MHz);
        checks++;
        if (pulse_cnt !== p0 || busy !== 1'b0 || stable_color !== COLOR_RED) begin
            errors++; $display("FAIL steady: pulses %0d busy %b stable %0d want 0 0 1",
                               pulse_cnt - p0, busy, stable_color);
        end
    endtask

    task automatic test_zero();
        int p0, busy_seen;
        p0 = pulse_cnt;
        do_sample(COLOR_NONE);
        do_sample(COLOR_NONE);
        checks++;
        if (stable_color !== COLOR_RED) begin
            errors++; $display("FAIL zero early: stable %0d want 1", stable_color);
        end
        do_sample(COLOR_NONE);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk_1MHz);
            if (busy) busy_seen++;
        end
        checks++;
        if (stable_color !== COLOR_NONE || pulse_cnt !== p0 || busy_seen !== 0) begin
            errors++; $display("FAIL zero: stable %0d pulses %0d busy %0d want 0 0 0",
                               stable_color, pulse_cnt - p0, busy_seen);
        end
    endtask

    task automatic test_restart();
        int p0;
        logic [1:0] seq [0:5];
        seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd1; seq[4] = 2'd1; seq[5] = 2'd1;
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) do_sample(seq[i]);
        checks++;
        if (pulse_cnt !== p0 || stable_color !== COLOR_NONE) begin
            errors++; $display("FAIL restart early: pulses %0d stable %0d want 0 0",
                               pulse_cnt - p0, stable_color);
        end
        do_sample(seq[5]);
        checks++;
        if (event_pulse !== 1'b1 || stable_color !== COLOR_RED) begin
            errors++; $display("FAIL restart confirm: pulse %b stable %0d want 1 1", event_pulse, stable_color);
        end
        exp_b[0] = 8'h52; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        capture(3);
        check_msg("restart", 3, 0);
    endtask

    task automatic test_back_to_back();
        int p0;
        for (int i = 0; i < 3; i++) do_sample(COLOR_NONE);
        checks++;
        if (stable_color !== COLOR_NONE) begin
            errors++; $display("FAIL b2b clear: stable %0d want 0", stable_color);
        end
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) do_sample(COLOR_RED);
        exp_b[0] = 8'h52; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        exp_b[3] = 8'h47; exp_b[4] = 8'h0D; exp_b[5] = 8'h0A;
        fork
            capture(6);
            begin
                repeat (30) @(posedge clk_1MHz);
                for (int i = 0; i < 3; i++) do_sample(COLOR_BLUE);
                for (int i = 0; i < 3; i++) do_sample(COLOR_GREEN);
            end
        join
        check_msg("b2b", 6, 0);
        checks++;
        if (pulse_cnt - p0 !== 3 || stable_color !== COLOR_GREEN) begin
            errors++; $display("FAIL b2b events: pulses %0d stable %0d want 3 2",
                               pulse_cnt - p0, stable_color);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        for (int i = 0; i < 3; i++) do_sample(COLOR_BLUE);
        repeat (500) @(posedge clk_1MHz);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midframe busy: got %b want 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, stable_color, event_pulse} !== 5'b1_0_00_0) begin
            errors++; $display("FAIL async reset: got %b want 10000",
                               {tx, busy, stable_color, event_pulse});
        end
        repeat (3) @(posedge clk_1MHz);
        #1 rst = 1'b0;
        bad = 0;
        repeat (4000) begin
            @(negedge clk_1MHz);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL post reset: %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_confirm_red();
        test_steady();
        test_zero();
        test_restart();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_event_uart.md
# color_event_uart

Downstream consumer of the colour detector's `filter`/`color` outputs. Samples each freshly computed colour, confirms it over several consecutive detection rounds, and when a new stable non-zero colour is confirmed, transmits a 3-byte ASCII message over a UART TX line (8N1). It sits between the colour detector and the board's serial link to the host/logger.

## Interface
- `CONFIRM_CNT`, 3: consecutive identical samples needed to confirm a colour (range 1..15).
- `CLKS_PER_BIT`, 104: clocks per UART bit (≈9615 baud at 1 MHz); min 4.
- `clk_1MHz`  in  1  system clock, same domain as the detector.
- `rst`  in  1  asynchronous, active-high reset.
- `filter`  in  2  detector filter select (0 red, 1 blue, 2 clear, 3 green).
- `color`  in  2  detector result (0 none, 1 red, 2 green, 3 blue).
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high while a message is being shifted out.
- `stable_color`  out  2  last confirmed colour.
- `event_pulse`  out  1  one-cycle pulse when `stable_color` changes to a non-zero value.

## Operation
- Sample strobe: `filter_q` registers `filter`; a sample is taken in a cycle where `filter==2 && filter_q==1` (the detector updates `color` on that same edge).
- Confirmation: regs `cand[1:0]`, `run[3:0]`. On sample: if `color==cand`, `run` increments, saturating at `CONFIRM_CNT`; else `cand<=color`, `run<=1`.
- Confirm event: in the cycle `run` first reaches `CONFIRM_CNT`, and only if `cand != stable_color`:
  - `cand==0`: `stable_color<=0`; no pulse, no message.
  - `cand!=0`: `stable_color<=cand`, `event_pulse` high for the next cycle, message request raised.
- Message: byte0 = 'R' 0x52 / 'G' 0x47 / 'B' 0x42 per colour, byte1 = 0x0D, byte2 = 0x0A.
- Pending slot: a request arriving while `busy` is stored in a 1-entry pending register (colour + valid); a newer request overwrites it. When the current message ends, the pending message starts; otherwise the FSM returns to idle.
- TX FSM: IDLE -> START (tx=0) -> DATA (8 bits, LSB first) -> STOP (tx=1) -> START of next byte, or after byte2 -> IDLE/next message. Every bit lasts exactly `CLKS_PER_BIT` cycles; bit counter 0..7, byte index 0..2.

## Timing
- Reset (async): `tx=1`, `busy=0`, `stable_color=0`, `event_pulse=0`, `cand=0`, `run=0`, pending empty, FSM IDLE. Reset mid-frame drops `tx` to 1 immediately; the partial frame is abandoned.
- Confirm at edge E (`run` reaches limit): `stable_color` and `event_pulse` valid after E; `busy` rises and `tx` falls at E+1 if idle.
- Message length: 30 × `CLKS_PER_BIT` cycles (3120 at default); `busy` drops the cycle after byte2's stop bit completes, unless pending is valid, in which case the next start bit follows with no idle gap and `busy` stays high.
- Detector round ≈1501 cycles, so at default one message spans ~2 rounds; pending slot absorbs this.
- Sample strobe coincident with message end: both handled same cycle; a newly raised request starts immediately rather than via pending.
- `run` saturation: further identical samples produce no further events.

## Structure
- Shared package `color_pkg`: colour codes (`COLOR_NONE/RED/GREEN/BLUE`), filter codes (`FILT_RED/BLUE/CLEAR/GREEN`), ASCII constants (`ASC_R`, `ASC_G`, `ASC_B`, `ASC_CR`, `ASC_LF`); shared with the detector.
- Sub-module `uart_tx_byte`: one 8N1 byte, `start`/`data[7:0]` in, `tx`/`done` out, parameter `CLKS_PER_BIT`. Top holds sampler, confirmation, pending slot and byte sequencer.

## Test plan
- Reset: assert `rst` mid-frame -> `tx=1`, `busy=0`, `stable_color=0` immediately; no further bits.
- Three rounds of `color=1` (`CONFIRM_CNT=3`) -> `event_pulse` once after third sample, `stable_color=1`, `tx` frames 0x52, 0x0D, 0x0A, each bit 104 cycles.
- Sequence 1,1,2,1,1,1 -> no event until sixth sample; `run` restarts on mismatch.
- Confirmed red, then 3 rounds blue then 3 rounds green, all during one message -> blue overwritten in pending; next message is 'G' (0x47) back-to-back, no idle gap.
- Confirmed red, then 3 rounds of `color=0`, then 3 rounds red -> `stable_color` goes 0 with no pulse/message, then red re-reported.
- Steady red for 10 rounds -> exactly one message.
